// File: rtl/alu_seq_pkg.sv
// Shared definitions for the ALU op sequencer.
//  - ALU select codes, the idle select value and the error sentinel result
//  - FSM state encoding
//  - command record width helper and the "screen without issuing" predicate
package alu_seq_pkg;

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_MUL  = 4'h2;
  localparam logic [3:0] OP_DIV  = 4'h3;
  localparam logic [3:0] OP_IDLE = 4'hF;

  localparam logic [7:0] ERR_SENTINEL = 8'hAC;

  // op + a + b, the tag is appended per instance
  localparam int CMD_BASE_W = 4 + 8 + 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  function automatic int cmd_w(input int tag_w);
    return CMD_BASE_W + tag_w;
  endfunction

  // Ops the ALU must never see: unknown opcodes and divide-by-zero.
  function automatic logic op_is_err(input logic [3:0] op, input logic [7:0] b);
    return (op > OP_DIV) || ((op == OP_DIV) && (b == 8'h00));
  endfunction

endpackage

// File: rtl/alu_cmd_fifo.sv
// Synchronous command FIFO.
//  clock/reset_n : rising-edge clock, synchronous active-low reset
//  push_i/wdata_i: write request and data (ignored when full)
//  pop_i/rdata_o : read request (ignored when empty), head of queue
//  full_o/empty_o: registered occupancy flags; no same-cycle bypass either way
module alu_cmd_fifo #(
  parameter int WIDTH = 24,
  parameter int DEPTH = 4
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  // extra MSB on each pointer distinguishes full from empty
  logic [AW:0]      wr_q, rd_q;
  logic             do_push, do_pop;

  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  assign empty_o = (wr_q == rd_q);
  assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign rdata_o = mem_q[rd_q[AW-1:0]];

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop)  rd_q <= rd_q + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem_q[wr_q[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/alu_op_sequencer.sv
// Command front end for the registered 8-bit ALU.
//  clock/reset_n          : rising-edge clock, synchronous active-low reset
//  cmd_*                  : host command channel (valid/ready), op/a/b/tag
//  rsp_*                  : tagged response channel (valid/ready), held until accepted
//  alu_a/alu_b/alu_sel    : registered ALU inputs, alu_sel parks at 4'hF when idle
//  alu_out/alu_carry      : ALU results, captured after ALU_LATENCY+1 WAIT cycles
//  busy                   : queued work or an op in flight
// One op in flight at a time, so responses come back in command order.
module alu_op_sequencer
  import alu_seq_pkg::*;
#(
  parameter int CMD_DEPTH   = 4,
  parameter int TAG_W       = 4,
  parameter int ALU_LATENCY = 1
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [3:0]       cmd_op,
  input  logic [7:0]       cmd_a,
  input  logic [7:0]       cmd_b,
  input  logic [TAG_W-1:0] cmd_tag,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [7:0]       rsp_result,
  output logic             rsp_carry,
  output logic             rsp_err,
  output logic [TAG_W-1:0] rsp_tag,
  output logic [7:0]       alu_a,
  output logic [7:0]       alu_b,
  output logic [3:0]       alu_sel,
  input  logic [7:0]       alu_out,
  input  logic             alu_carry,
  output logic             busy
);

  localparam int CW    = cmd_w(TAG_W);
  localparam int CNT_W = $clog2(ALU_LATENCY + 2);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ALU_LATENCY);

  logic [CW-1:0]    head;
  logic             fifo_full, fifo_empty, pop;
  logic [3:0]       h_op;
  logic [7:0]       h_a, h_b;
  logic [TAG_W-1:0] h_tag;

  alu_cmd_fifo #(.WIDTH(CW), .DEPTH(CMD_DEPTH)) u_fifo (
    .clock   (clock),
    .reset_n (reset_n),
    .push_i  (cmd_valid),
    .wdata_i ({cmd_op, cmd_a, cmd_b, cmd_tag}),
    .pop_i   (pop),
    .rdata_o (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign {h_op, h_a, h_b, h_tag} = head;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       alu_a_q, alu_a_d, alu_b_q, alu_b_d;
  logic [3:0]       alu_sel_q, alu_sel_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [7:0]       rsp_result_q, rsp_result_d;
  logic             rsp_carry_q, rsp_carry_d;
  logic             rsp_err_q, rsp_err_d;
  logic [TAG_W-1:0] rsp_tag_q, rsp_tag_d;
  logic             dispatch;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    alu_sel_d    = alu_sel_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_result_d = rsp_result_q;
    rsp_carry_d  = rsp_carry_q;
    rsp_err_d    = rsp_err_q;
    rsp_tag_d    = rsp_tag_q;
    dispatch     = 1'b0;

    case (state_q)
      ST_IDLE: dispatch = ~fifo_empty;
      ST_WAIT: begin
        if (cnt_q == CNT_LAST) begin
          rsp_result_d = alu_out;
          rsp_carry_d  = alu_carry;
          rsp_err_d    = 1'b0;
          rsp_valid_d  = 1'b1;
          alu_sel_d    = OP_IDLE;
          state_d      = ST_RESP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_RESP: begin
        if (rsp_valid_q && rsp_ready) begin
          if (!fifo_empty) begin
            dispatch = 1'b1;    // back-to-back on the handshake edge
          end else begin
            rsp_valid_d = 1'b0;
            state_d     = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Dispatch overrides whatever the state arm set; errors are answered
    // directly so the ALU never sees them and alu_sel stays parked.
    if (dispatch) begin
      rsp_tag_d = h_tag;
      if (op_is_err(h_op, h_b)) begin
        rsp_result_d = ERR_SENTINEL;
        rsp_carry_d  = 1'b0;
        rsp_err_d    = 1'b1;
        rsp_valid_d  = 1'b1;
        state_d      = ST_RESP;
      end else begin
        alu_a_d     = h_a;
        alu_b_d     = h_b;
        alu_sel_d   = h_op;
        cnt_d       = '0;
        rsp_valid_d = 1'b0;
        state_d     = ST_WAIT;
      end
    end
  end

  assign pop = dispatch;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_sel_q    <= OP_IDLE;
      rsp_valid_q  <= 1'b0;
      rsp_result_q <= '0;
      rsp_carry_q  <= 1'b0;
      rsp_err_q    <= 1'b0;
      rsp_tag_q    <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      alu_sel_q    <= alu_sel_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_result_q <= rsp_result_d;
      rsp_carry_q  <= rsp_carry_d;
      rsp_err_q    <= rsp_err_d;
      rsp_tag_q    <= rsp_tag_d;
    end
  end

  assign cmd_ready  = ~fifo_full;
  assign busy       = ~fifo_empty | (state_q != ST_IDLE);
  assign rsp_valid  = rsp_valid_q;
  assign rsp_result = rsp_result_q;
  assign rsp_carry  = rsp_carry_q;
  assign rsp_err    = rsp_err_q;
  assign rsp_tag    = rsp_tag_q;
  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign alu_sel    = alu_sel_q;

endmodule
